// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter in front of a single memory slave port with
// waitrequest flow control. One transfer per grant; each grant passes
// through IDLE so the masters are re-arbitrated after every transfer.
//
// state | meaning
// IDLE  | no owner, slave port driven to zero, requests sampled for arbitration
// BUSY0 | m0 owns the slave port until completion, timeout or request drop
// BUSY1 | m1 owns the slave port until completion, timeout or request drop
module mips_bus_arbiter #(
    parameter int RR_MODE      = 1,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // The abort fires on the cycle that would be the WAIT_TIMEOUT-th wait,
    // so compare against the count of waits already seen.
    localparam logic [7:0] TMO_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       last_m1, last_m1_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_nxt;
    logic       req0, req1;
    logic       own_req, tmo, done;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign own_req = (state == BUSY1) ? req1 : req0;
    assign tmo     = (state != IDLE) && own_req && s_waitrequest && (wait_cnt == TMO_LAST);
    assign done    = (state != IDLE) && own_req && !s_waitrequest;

    // State, counter, fairness pointer and sticky error register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_m1     <= 1'b1;
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_m1     <= last_m1_nxt;
            wait_cnt    <= wait_cnt_nxt;
            timeout_err <= err_nxt;
        end
    end

    // Arbitration and transfer termination
    always_comb begin
        state_nxt    = state;
        last_m1_nxt  = last_m1;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = timeout_err;
        case (state)
            IDLE: begin
                wait_cnt_nxt = 8'd0;
                if (req0 && req1) begin
                    // Round-robin hands a tie to whoever was not granted last
                    if ((RR_MODE != 0) && !last_m1) begin
                        state_nxt   = BUSY1;
                        last_m1_nxt = 1'b1;
                    end else begin
                        state_nxt   = BUSY0;
                        last_m1_nxt = 1'b0;
                    end
                end else if (req0) begin
                    state_nxt   = BUSY0;
                    last_m1_nxt = 1'b0;
                end else if (req1) begin
                    state_nxt   = BUSY1;
                    last_m1_nxt = 1'b1;
                end
            end
            BUSY0, BUSY1: begin
                if (!own_req || done || tmo) begin
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
                if (tmo) begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave port mux and per-master handshake; non-owners stall while requesting
    always_comb begin
        s_address      = 32'd0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = 32'd0;
        s_byteenable   = 4'd0;
        grant          = 2'b00;
        m0_readdata    = 32'd0;
        m1_readdata    = 32'd0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        case (state)
            BUSY0: begin
                grant          = 2'b01;
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_write        = m0_write & ~tmo;
                s_read         = m0_read & ~m0_write & ~tmo;
                m0_waitrequest = req0 & s_waitrequest & ~tmo;
                m0_readdata    = done ? s_readdata : 32'd0;
            end
            BUSY1: begin
                grant          = 2'b10;
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write & ~tmo;
                s_read         = m1_read & ~m1_write & ~tmo;
                m1_waitrequest = req1 & s_waitrequest & ~tmo;
                m1_readdata    = done ? s_readdata : 32'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream; directed vectors, corner sequences, then
// random traffic checked against a transaction-level reference model.
module tb_mips_bus_arbiter;

    localparam int WT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, s_readdata;
    logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
    logic [3:0]  m0_byteenable, m1_byteenable;

    logic [31:0] m0_rd_o [2];
    logic [31:0] m1_rd_o [2];
    logic        m0_wt_o [2];
    logic        m1_wt_o [2];
    logic [31:0] s_addr_o [2];
    logic        s_rd_o [2];
    logic        s_wr_o [2];
    logic [31:0] s_wd_o [2];
    logic [3:0]  s_be_o [2];
    logic [1:0]  grant_o [2];
    logic        terr_o [2];

    int errors = 0;
    int checks = 0;

    // Model state per instance: owner -1 = nobody
    int m_owner [2];
    int m_waits [2];
    int m_last [2];
    bit m_err [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mips_bus_arbiter #(.RR_MODE((g == 0) ? 1 : 0), .WAIT_TIMEOUT(WT)) dut (
            .clk(clk), .reset(reset),
            .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
            .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
            .m0_readdata(m0_rd_o[g]), .m0_waitrequest(m0_wt_o[g]),
            .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
            .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
            .m1_readdata(m1_rd_o[g]), .m1_waitrequest(m1_wt_o[g]),
            .s_address(s_addr_o[g]), .s_read(s_rd_o[g]), .s_write(s_wr_o[g]),
            .s_writedata(s_wd_o[g]), .s_byteenable(s_be_o[g]),
            .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
            .grant(grant_o[g]), .timeout_err(terr_o[g])
        );
    end

    typedef struct {
        logic r0, w0, r1, w1, sw;
        logic [1:0] grant;
        logic wt0, wt1, srd, swr, err;
    } vec_t;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_address = 32'd0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'd0; m0_byteenable = 4'd0;
        m1_address = 32'd0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'd0; m1_byteenable = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        s_waitrequest = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_waits[k] = 0; m_last[k] = 1; m_err[k] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [159:0] observe(input int k);
        return 160'({grant_o[k], s_rd_o[k], s_wr_o[k], s_addr_o[k], s_wd_o[k], s_be_o[k],
                     m0_wt_o[k], m1_wt_o[k], m0_rd_o[k], m1_rd_o[k], terr_o[k]});
    endfunction

    // Expected outputs from the owner/waits bookkeeping and current inputs
    task automatic model_check(input int k, input int cyc);
        logic req0, req1, oreq, tmo, wr, rd;
        logic [1:0]  e_grant;
        logic        e_srd, e_swr, e_w0, e_w1;
        logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
        logic [3:0]  e_be;
        int n;
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        e_grant = 2'b00; e_srd = 1'b0; e_swr = 1'b0; e_addr = 32'd0; e_wd = 32'd0; e_be = 4'd0;
        e_w0 = req0; e_w1 = req1; e_rd0 = 32'd0; e_rd1 = 32'd0;
        n = m_owner[k];
        if (n >= 0) begin
            oreq = (n == 1) ? req1 : req0;
            wr   = (n == 1) ? m1_write : m0_write;
            rd   = (n == 1) ? m1_read : m0_read;
            tmo  = oreq && s_waitrequest && (m_waits[k] + 1 == WT);
            e_grant = (n == 1) ? 2'b10 : 2'b01;
            e_addr  = (n == 1) ? m1_address : m0_address;
            e_wd    = (n == 1) ? m1_writedata : m0_writedata;
            e_be    = (n == 1) ? m1_byteenable : m0_byteenable;
            e_swr   = wr && !tmo;
            e_srd   = rd && !wr && !tmo;
            if (n == 1) begin
                e_w1  = oreq && s_waitrequest && !tmo;
                e_rd1 = (oreq && !s_waitrequest) ? s_readdata : 32'd0;
            end else begin
                e_w0  = oreq && s_waitrequest && !tmo;
                e_rd0 = (oreq && !s_waitrequest) ? s_readdata : 32'd0;
            end
        end
        chk($sformatf("rand%0d_inst%0d", cyc, k), observe(k),
            160'({e_grant, e_srd, e_swr, e_addr, e_wd, e_be, e_w0, e_w1, e_rd0, e_rd1, m_err[k]}));
    endtask

    // Advance the bookkeeping across one rising edge
    task automatic model_step(input int k);
        logic req0, req1, oreq;
        int w;
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        if (m_owner[k] < 0) begin
            w = -1;
            if (req0 && req1) w = (k == 0) ? 1 - m_last[k] : 0;
            else if (req0) w = 0;
            else if (req1) w = 1;
            if (w >= 0) begin
                m_owner[k] = w; m_last[k] = w; m_waits[k] = 0;
            end
        end else begin
            oreq = (m_owner[k] == 1) ? req1 : req0;
            if (!oreq || !s_waitrequest) begin
                m_owner[k] = -1;
            end else if (m_waits[k] + 1 == WT) begin
                m_owner[k] = -1; m_err[k] = 1'b1;
            end else begin
                m_waits[k]++;
            end
        end
    endtask

    initial begin
        vec_t tbl [13];
        int busy_cnt;
        bit aborted;
        bit hold;
        logic [1:0] pick;

        //       r0 w0 r1 w1 sw grant  wt0 wt1 srd swr err
        tbl[0]  = '{1, 0, 1, 0, 0, 2'b00, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 1, 2'b01, 1, 1, 1, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 2'b01, 0, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 0, 2'b10, 0, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 1, 2'b01, 1, 0, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0};

        // Reset state, with a request already present
        reset = 1'b0;
        idle_inputs();
        m0_read = 1'b1; m0_address = 32'hBFC0_0000;
        s_waitrequest = 1'b0; s_readdata = 32'h0;
        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_grant%0d", k), 160'(grant_o[k]), 160'(2'b00));
            chk($sformatf("reset_sport%0d", k), 160'({s_addr_o[k], s_rd_o[k], s_wr_o[k], s_wd_o[k], s_be_o[k]}), 160'(0));
            chk($sformatf("reset_terr%0d", k), 160'(terr_o[k]), 160'(0));
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors from a freshly reset round-robin instance
        m0_address = 32'h0000_1000; m1_address = 32'h0000_2000;
        for (int i = 0; i < 13; i++) begin
            tick();
            m0_read = tbl[i].r0; m0_write = tbl[i].w0;
            m1_read = tbl[i].r1; m1_write = tbl[i].w1;
            s_waitrequest = tbl[i].sw;
            sample();
            chk($sformatf("vec%0d", i),
                160'({grant_o[0], m0_wt_o[0], m1_wt_o[0], s_rd_o[0], s_wr_o[0], terr_o[0]}),
                160'({tbl[i].grant, tbl[i].wt0, tbl[i].wt1, tbl[i].srd, tbl[i].swr, tbl[i].err}));
        end

        // Idle bus for 10 cycles
        tick();
        idle_inputs();
        s_waitrequest = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            for (int k = 0; k < 2; k++)
                chk($sformatf("idle%0d_inst%0d", i, k),
                    160'({s_addr_o[k], s_wd_o[k], s_be_o[k], s_rd_o[k], s_wr_o[k], grant_o[k], m0_wt_o[k], m1_wt_o[k]}), 160'(0));
            tick();
        end

        // m0 read of the reset vector with two slave wait cycles
        m0_read = 1'b1; m0_address = 32'hBFC0_0000; m0_byteenable = 4'hF;
        s_waitrequest = 1'b1; s_readdata = 32'h1234_5678;
        sample();
        chk("rd_arb_grant", 160'(grant_o[0]), 160'(2'b00));
        tick(); sample();
        chk("rd_busy1", 160'({grant_o[0], s_addr_o[0], s_rd_o[0], m0_wt_o[0], m0_rd_o[0]}),
            160'({2'b01, 32'hBFC0_0000, 1'b1, 1'b1, 32'h0}));
        tick(); sample();
        chk("rd_busy2", 160'({grant_o[0], m0_wt_o[0]}), 160'({2'b01, 1'b1}));
        tick();
        s_waitrequest = 1'b0;
        sample();
        chk("rd_busy3", 160'({grant_o[0], m0_wt_o[0], m0_rd_o[0]}), 160'({2'b01, 1'b0, 32'h1234_5678}));
        tick();
        m0_read = 1'b0;
        sample();
        chk("rd_after", 160'(grant_o[0]), 160'(2'b00));

        // Four back-to-back ties: alternate on round-robin, m0 on fixed priority
        do_reset();
        tick();
        m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); sample();
            chk($sformatf("tie%0d_rr", i), 160'(grant_o[0]), 160'((i % 2 == 0) ? 2'b01 : 2'b10));
            chk($sformatf("tie%0d_fp", i), 160'(grant_o[1]), 160'(2'b01));
            tick();
        end
        idle_inputs();
        tick(); sample();

        // m1 write while m0 stalls behind it
        tick();
        m1_write = 1'b1; m1_address = 32'hBFC0_0100; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'b0011;
        s_waitrequest = 1'b1;
        tick();
        m0_read = 1'b1; m0_address = 32'h0000_0040;
        sample();
        for (int k = 0; k < 2; k++)
            chk($sformatf("wr_busy_inst%0d", k),
                160'({grant_o[k], s_wr_o[k], s_rd_o[k], s_addr_o[k], s_wd_o[k], s_be_o[k], m0_wt_o[k], m0_rd_o[k], m1_wt_o[k]}),
                160'({2'b10, 1'b1, 1'b0, 32'hBFC0_0100, 32'hDEAD_BEEF, 4'b0011, 1'b1, 32'h0, 1'b1}));
        tick();
        s_waitrequest = 1'b0;
        sample();
        chk("wr_done", 160'({s_wr_o[0], m1_wt_o[0], m0_wt_o[0]}), 160'({1'b1, 1'b0, 1'b1}));
        tick();
        m1_write = 1'b0;
        sample();
        chk("wr_m0_waits", 160'({grant_o[0], m0_wt_o[0]}), 160'({2'b00, 1'b1}));
        tick(); sample();
        chk("wr_m0_served", 160'({grant_o[0], m0_wt_o[0]}), 160'({2'b01, 1'b0}));
        tick();
        idle_inputs();

        // Slave never answers: abort on the 64th wait cycle, sticky error
        tick();
        m0_read = 1'b1; m0_address = 32'hBFC0_0000; s_waitrequest = 1'b1; s_readdata = 32'hCAFE_F00D;
        sample();
        busy_cnt = 0;
        aborted = 1'b0;
        for (int i = 0; i < 100 && !aborted; i++) begin
            tick(); sample();
            if (grant_o[0] == 2'b01) busy_cnt++;
            if (!m0_wt_o[0]) begin
                aborted = 1'b1;
                for (int k = 0; k < 2; k++)
                    chk($sformatf("tmo_abort_inst%0d", k),
                        160'({grant_o[k], s_rd_o[k], s_wr_o[k], m0_rd_o[k], terr_o[k]}),
                        160'({2'b01, 1'b0, 1'b0, 32'h0, 1'b0}));
            end
        end
        chk("tmo_aborted", 160'(aborted), 160'(1));
        chk("tmo_cycle", 160'(busy_cnt), 160'(WT));
        tick();
        m0_read = 1'b0;
        sample();
        chk("tmo_flag", 160'({terr_o[0], terr_o[1], grant_o[0]}), 160'({1'b1, 1'b1, 2'b00}));
        tick();
        m1_write = 1'b1; s_waitrequest = 1'b0;
        tick(); sample();
        chk("tmo_sticky", 160'({grant_o[0], m1_wt_o[0], terr_o[0]}), 160'({2'b10, 1'b0, 1'b1}));

        // Asynchronous reset in the middle of a BUSY1 write
        do_reset();
        chk("tmo_cleared", 160'({terr_o[0], terr_o[1]}), 160'(0));
        tick();
        m1_write = 1'b1; m1_address = 32'h0000_0200; s_waitrequest = 1'b1;
        tick(); sample();
        chk("ar_busy1", 160'({grant_o[0], s_wr_o[0]}), 160'({2'b10, 1'b1}));
        #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("ar_async_inst%0d", k), 160'({grant_o[k], s_wr_o[k], s_addr_o[k]}), 160'(0));
        m0_read = 1'b1; s_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(); sample();
        for (int k = 0; k < 2; k++)
            chk($sformatf("ar_first_tie_inst%0d", k), 160'(grant_o[k]), 160'(2'b01));

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 700; c++) begin
            tick();
            hold = (c >= 300 && c < 400);
            if (c == 300) begin
                m0_read = 1'b1; m1_write = 1'b1;
            end
            if (!hold && $urandom_range(0, 9) < 4) begin
                pick = 2'($urandom_range(0, 3));
                m0_read = pick[0]; m0_write = pick[1];
            end
            if (!hold && $urandom_range(0, 9) < 4) begin
                pick = 2'($urandom_range(0, 3));
                m1_read = pick[0]; m1_write = pick[1];
            end
            m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
            m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
            s_readdata = $urandom;
            s_waitrequest = hold ? 1'b1 : 1'($urandom_range(0, 1));
            sample();
            for (int k = 0; k < 2; k++) begin
                model_check(k, c);
                model_step(k);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter RR_MODE, default 1, 1 = round-robin between masters, 0 = fixed priority m0 over m1; SHALL be supported.
REQ-002 Parameter WAIT_TIMEOUT, default 64, max cycles a granted transfer may see s_waitrequest high before abort (range 2..255); SHALL be supported.
REQ-003 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  reset is asynchronous and active-low; reset=0 SHALL clear all state immediately.
REQ-005 m0_address / m1_address  in  32  master byte address (0xBFC00000 = reset vector region).
REQ-006 m0_read, m0_write / m1_read, m1_write  in  1 each  master request strobes.
REQ-007 m0_writedata / m1_writedata  in  32; m0_byteenable / m1_byteenable  in  4.
REQ-008 m0_readdata / m1_readdata  out  32; m0_waitrequest / m1_waitrequest  out  1.
REQ-009 s_address  out  32; s_read, s_write  out  1; s_writedata  out  32; s_byteenable  out  4.
REQ-010 s_readdata  in  32; s_waitrequest  in  1  shared memory slave port.
REQ-011 grant  out  2  one-hot {m1,m0}, 00 when idle; timeout_err  out  1  sticky abort flag.

Function
REQ-012 SHALL implement states IDLE, BUSY0, BUSY1.
REQ-013 Request from mN = mN_read | mN_write; simultaneous read and write from one master SHALL be treated as write.
REQ-014 IDLE: no request -> stay IDLE; requests sampled at clock edge, winner's BUSYn entered next cycle (1-cycle arbitration latency).
REQ-015 Both request in IDLE: RR_MODE=1 -> master not granted last; RR_MODE=0 -> m0; after reset last-granted SHALL be m1 (m0 wins first tie).
REQ-016 BUSYn: s_* outputs SHALL mirror mN address/read/write/writedata/byteenable combinationally; grant bit n = 1.
REQ-017 Transfer completes in the BUSYn cycle where s_waitrequest=0; that cycle mN_waitrequest=0 and mN_readdata=s_readdata.
REQ-018 On completion, FSM SHALL return to IDLE (no back-to-back grant without re-arbitration); last-granted updated to n.
REQ-019 Non-granted master's waitrequest SHALL be 1 whenever it requests; its readdata SHALL be 0.
REQ-020 Any master with no request SHALL see waitrequest=0 and readdata=0.
REQ-021 Wait counter (8 bit) SHALL clear on BUSY entry, increment each BUSY cycle with s_waitrequest=1.
REQ-022 When counter reaches WAIT_TIMEOUT: s_read/s_write SHALL drop that cycle, mN_waitrequest=0, mN_readdata=0, timeout_err set, return to IDLE.
REQ-023 timeout_err SHALL remain 1 until reset.
REQ-024 Master dropping its request while granted (protocol violation) SHALL abort to IDLE next edge without setting timeout_err.
REQ-025 In IDLE, all s_* outputs SHALL be 0.

Reset
REQ-026 reset=0 SHALL force IDLE, grant=00, s_read=s_write=0, s_address/s_writedata=0, s_byteenable=0, timeout_err=0, counter=0, last-granted=m1, regardless of clk.
REQ-027 reset asserted mid-transfer SHALL drop s_read/s_write asynchronously; pending transfer is lost, not retried.
REQ-028 First arbitration SHALL occur on the first rising edge after reset returns to 1.

Verification
REQ-029 m0 read 0xBFC00000, slave waitrequest 2 cycles, s_readdata=0x12345678 -> grant=01 one cycle after request, m0_readdata=0x12345678 with m0_waitrequest=0 on 3rd BUSY0 cycle.
REQ-030 m0 and m1 request together, RR_MODE=1, repeated 4 times -> grant order m0,m1,m0,m1; with RR_MODE=0 -> m0 every tie.
REQ-031 m1 write 0xBFC00100 data 0xDEADBEEF byteenable 0011 -> s_write=1, s_writedata=0xDEADBEEF, s_byteenable=0011 during BUSY1; m0 stalled with waitrequest=1 meanwhile.
REQ-032 Slave holds waitrequest=1, WAIT_TIMEOUT=64 -> abort on 64th wait cycle, m0_readdata=0, timeout_err=1 until reset.
REQ-033 reset=0 asserted between clock edges during BUSY1 -> s_write=0 and grant=00 before next edge; after release m0/m1 tie grants m0.
REQ-034 Idle bus, no requests for 10 cycles -> all s_* 0, both waitrequests 0, grant=00.
